seg_argmax: RTL and testbench
=============================

# seg_argmax

Per-pixel classification head placed directly downstream of the three-layer feature extractor. It consumes the 12-channel signed fixed-point feature vector streamed with raster coordinates and emits the index of the largest channel (class label) and its score through a fixed 4-stage pipeline. Coordinates are delayed by the same latency. An optional per-frame class histogram is compiled in by macro.

## Interface
- HEIGHT, -1: active image height in pixels
- WIDTH, -1: active image width in pixels
- W_HEIGHT, -1: total frame height, including blanking
- W_WIDTH, -1: total frame width, including blanking
- UNITS, 12: number of feature channels (2..16)
- FIXED_BITW, 13: channel word width, two's complement (5 int + 8 frac)
- clock  in  1  sole clock; all logic on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- in_y  in  FIXED_BITW*UNITS  packed [0:N-1] vector; channel k = bits [k*FIXED_BITW +: FIXED_BITW]
- in_vcnt  in  ceil(log2(W_HEIGHT))  row of in_y
- in_hcnt  in  ceil(log2(W_WIDTH))  column of in_y
- out_label  out  LABEL_BITW=ceil(log2(UNITS))  index of max channel
- out_score  out  FIXED_BITW  value of max channel, signed
- out_vcnt, out_hcnt  out  as inputs  delayed coordinates
- hist_valid  out  1  one-cycle frame-histogram strobe (SEG_HIST_EN only)
- hist_data  out  UNITS*CNT_BITW  per-class counts, class 0 in the low slice (SEG_HIST_EN only)

## Operation
- The stream is always valid, one pixel per clock. There is no handshake. Blanking pixels flow through unchanged.
- Comparisons are signed on the full FIXED_BITW.
- Tie rule: the lower channel index wins at every compare node, so the global result is the lowest index among the equal maxima.
- Tree:
  - S1: pairs (0,1)…(10,11) → 6 candidates.
  - S2: pairs → 3 candidates.
  - S3: compare candidate A vs B, and register candidate C.
  - S4: compare winner(A,B) vs C.
- Each candidate carries a {label, score} pair.
- For UNITS ≠ 12, unpaired candidates pass through a register without comparison. The depth stays 4.
- Histogram (SEG_HIST_EN):
  - UNITS counters of CNT_BITW = ceil(log2(HEIGHT*WIDTH+1)) bits.
  - At the S4 output, each pixel with out_vcnt<HEIGHT and out_hcnt<WIDTH increments counter[out_label].
  - On the last active pixel (HEIGHT-1, WIDTH-1), hist_data is loaded with the counts including that pixel, and hist_valid pulses high one cycle later.
  - All counters clear to 0 in the same cycle, so the next pixel starts a fresh frame. There is no dead pixel.
- Counters cannot overflow, because CNT_BITW is sized for a full frame.

## Timing
- Latency is 4 clocks, from in_* sampled at edge n to out_* valid after edge n+4. Throughput is 1 pixel/clock.
- Reset values: out_label=0, out_score=0, out_vcnt=0, out_hcnt=0, hist_valid=0, hist_data=0, all pipeline and counter registers 0.
- For the 4 cycles after rst deasserts, outputs carry the zeroed pipeline contents. Downstream treats (0,0) during this window as non-meaningful.
- Reset asserted mid-frame:
  - The pipeline and counters clear on that edge.
  - The histogram for the interrupted frame is never emitted.
  - The first frame after reset is counted only from the pixels that reach S4 after reset.
- hist_valid rises one clock after the cycle where out_(vcnt,hcnt) = (HEIGHT-1, WIDTH-1).
- hist_data holds its value until the next strobe or reset.

## Configuration
- SEG_HIST_EN defined: counters, snapshot register, hist_valid and hist_data are present.
- SEG_HIST_EN undefined:
  - Ports hist_valid/hist_data are removed.
  - No histogram logic is synthesized.
  - Argmax behaviour and latency are identical.

## Structure
- Package seg_pkg:
  - constants SEG_UNITS=12, SEG_FIXED_BITW=13, SEG_LATENCY=4
  - ceil-log2 function
  - candidate typedef {label, signed score}
- Sub-module seg_cmp2: a registered two-candidate compare cell with lower-index tie priority, instantiated 11 times across the tree.
- Coordinate delay is a 4-deep shift register inside seg_argmax.

## Test plan
- Channel 7 = 0x0100 (+1.0), others 0x1F00 (−1.0) → out_label=7, out_score=0x0100, 4 clocks later.
- All channels = 0x1FFF (−1/256) → label 0, score 0x1FFF. Channels 3 and 9 both 0x0FFF, rest 0 → label 3.
- Signed check: ch0 = 0x1000 (most negative), ch1 = 0x0000 → label 1, not 0.
- Sweep a 2×4 active image inside a 3×6 window (HEIGHT=2, WIDTH=4, W_HEIGHT=3, W_WIDTH=6) with label = hcnt%2:
  - hist_data = {4,4,0…}.
  - hist_valid is high exactly one cycle after out at (1,3).
  - Blanking pixels are not counted.
- Back-to-back frames → second strobe shows the second frame's counts only (no carry-over).
- Assert rst at (1,1) of a frame for one cycle:
  - all outputs = 0 next cycle.
  - no strobe for that frame.
  - next full frame histogram is correct.

Source files
------------

// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Brief    : Shared constants, candidate type and ceil-log2 helper for the
//            per-pixel argmax classification head.
// Revision : 1.0 - initial release
// ============================================================================
package seg_pkg;

    localparam int SEG_UNITS      = 12;
    localparam int SEG_FIXED_BITW = 13;
    localparam int SEG_LATENCY    = 4;
    localparam int SEG_LABEL_BITW = 4;

    // {label, score} pair for the default channel configuration
    typedef struct packed {
        logic        [SEG_LABEL_BITW-1:0] label;
        logic signed [SEG_FIXED_BITW-1:0] score;
    } cand_t;

    // Never returns less than 1 so that derived vector widths stay legal
    function automatic int seg_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_cmp2.sv
`default_nettype none
// ============================================================================
// Module   : seg_cmp2
// Brief    : Registered two-candidate signed compare; candidate A is the lower
//            channel index and wins ties.
// Revision : 1.0 - initial release
// ============================================================================
module seg_cmp2
    import seg_pkg::*;
#(
    parameter int LABEL_BITW = SEG_LABEL_BITW,
    parameter int FIXED_BITW = SEG_FIXED_BITW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LABEL_BITW-1:0] i_a_label,
    input  logic [FIXED_BITW-1:0] i_a_score,
    input  logic [LABEL_BITW-1:0] i_b_label,
    input  logic [FIXED_BITW-1:0] i_b_score,
    output logic [LABEL_BITW-1:0] o_label,
    output logic [FIXED_BITW-1:0] o_score
);

    logic                  w_take_b;
    logic [LABEL_BITW-1:0] r_label;
    logic [FIXED_BITW-1:0] r_score;

    assign w_take_b = $signed(i_b_score) > $signed(i_a_score);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_label <= '0;
            r_score <= '0;
        end else begin
            r_label <= w_take_b ? i_b_label : i_a_label;
            r_score <= w_take_b ? i_b_score : i_a_score;
        end
    end

    assign o_label = r_label;
    assign o_score = r_score;

endmodule
`default_nettype wire

// File: rtl/seg_argmax.sv
`default_nettype none
// ============================================================================
// Module   : seg_argmax
// Brief    : 4-stage argmax tree over a streamed feature vector with delayed
//            raster coordinates. Define SEG_HIST_EN for the per-frame class
//            histogram (hist_valid / hist_data).
// Revision : 1.0 - initial release
// ============================================================================
module seg_argmax
    import seg_pkg::*;
#(
    parameter  int HEIGHT      = 480,
    parameter  int WIDTH       = 640,
    parameter  int W_HEIGHT    = 525,
    parameter  int W_WIDTH     = 800,
    parameter  int UNITS       = SEG_UNITS,
    parameter  int FIXED_BITW  = SEG_FIXED_BITW,
    localparam int c_label_bitw = seg_clog2(UNITS),
    localparam int c_vcnt_bitw  = seg_clog2(W_HEIGHT),
`ifdef SEG_HIST_EN
    localparam int c_cnt_bitw   = seg_clog2(HEIGHT * WIDTH + 1),
`endif
    localparam int c_hcnt_bitw  = seg_clog2(W_WIDTH)
) (
    input  logic                          clock,
    input  logic                          rst,
    input  logic [FIXED_BITW*UNITS-1:0]   in_y,
    input  logic [c_vcnt_bitw-1:0]        in_vcnt,
    input  logic [c_hcnt_bitw-1:0]        in_hcnt,
    output logic [c_label_bitw-1:0]       out_label,
    output logic [FIXED_BITW-1:0]         out_score,
    output logic [c_vcnt_bitw-1:0]        out_vcnt,
`ifdef SEG_HIST_EN
    output logic                          hist_valid,
    output logic [UNITS*c_cnt_bitw-1:0]   hist_data,
`endif
    output logic [c_hcnt_bitw-1:0]        out_hcnt
);

    localparam int c_lw = c_label_bitw;
    localparam int c_fb = FIXED_BITW;
    localparam int c_n0 = UNITS;
    localparam int c_n1 = (c_n0 + 1) / 2;
    localparam int c_n2 = (c_n1 + 1) / 2;
    localparam int c_n3 = (c_n2 + 1) / 2;
    localparam int c_n4 = (c_n3 + 1) / 2;

    logic [c_n0*c_lw-1:0] w_lab0;
    logic [c_n1*c_lw-1:0] w_lab1;
    logic [c_n1*c_fb-1:0] w_sc1;
    logic [c_n2*c_lw-1:0] w_lab2;
    logic [c_n2*c_fb-1:0] w_sc2;
    logic [c_n3*c_lw-1:0] w_lab3;
    logic [c_n3*c_fb-1:0] w_sc3;
    logic [c_n4*c_lw-1:0] w_lab4;
    logic [c_n4*c_fb-1:0] w_sc4;

    for (genvar j = 0; j < c_n0; j++) begin : g_lab0
        assign w_lab0[j*c_lw +: c_lw] = c_lw'(j);
    end

    // Each level pairs (2j, 2j+1) of the level below; an odd leftover is only registered
    for (genvar j = 0; j < c_n1; j++) begin : g_s1
        if (2*j+1 < c_n0) begin : g_cmp
            seg_cmp2 #(.LABEL_BITW(c_lw), .FIXED_BITW(c_fb)) u_cmp2 (
                .clk(clock), .rst(rst),
                .i_a_label(w_lab0[2*j*c_lw +: c_lw]),     .i_a_score(in_y[2*j*c_fb +: c_fb]),
                .i_b_label(w_lab0[(2*j+1)*c_lw +: c_lw]), .i_b_score(in_y[(2*j+1)*c_fb +: c_fb]),
                .o_label(w_lab1[j*c_lw +: c_lw]),         .o_score(w_sc1[j*c_fb +: c_fb]));
        end else begin : g_pass
            logic [c_lw-1:0] r_lab;
            logic [c_fb-1:0] r_sc;
            always_ff @(posedge clock) begin
                if (rst) begin r_lab <= '0; r_sc <= '0; end
                else begin r_lab <= w_lab0[2*j*c_lw +: c_lw]; r_sc <= in_y[2*j*c_fb +: c_fb]; end
            end
            assign w_lab1[j*c_lw +: c_lw] = r_lab;
            assign w_sc1[j*c_fb +: c_fb]  = r_sc;
        end
    end

    for (genvar j = 0; j < c_n2; j++) begin : g_s2
        if (2*j+1 < c_n1) begin : g_cmp
            seg_cmp2 #(.LABEL_BITW(c_lw), .FIXED_BITW(c_fb)) u_cmp2 (
                .clk(clock), .rst(rst),
                .i_a_label(w_lab1[2*j*c_lw +: c_lw]),     .i_a_score(w_sc1[2*j*c_fb +: c_fb]),
                .i_b_label(w_lab1[(2*j+1)*c_lw +: c_lw]), .i_b_score(w_sc1[(2*j+1)*c_fb +: c_fb]),
                .o_label(w_lab2[j*c_lw +: c_lw]),         .o_score(w_sc2[j*c_fb +: c_fb]));
        end else begin : g_pass
            logic [c_lw-1:0] r_lab;
            logic [c_fb-1:0] r_sc;
            always_ff @(posedge clock) begin
                if (rst) begin r_lab <= '0; r_sc <= '0; end
                else begin r_lab <= w_lab1[2*j*c_lw +: c_lw]; r_sc <= w_sc1[2*j*c_fb +: c_fb]; end
            end
            assign w_lab2[j*c_lw +: c_lw] = r_lab;
            assign w_sc2[j*c_fb +: c_fb]  = r_sc;
        end
    end

    for (genvar j = 0; j < c_n3; j++) begin : g_s3
        if (2*j+1 < c_n2) begin : g_cmp
            seg_cmp2 #(.LABEL_BITW(c_lw), .FIXED_BITW(c_fb)) u_cmp2 (
                .clk(clock), .rst(rst),
                .i_a_label(w_lab2[2*j*c_lw +: c_lw]),     .i_a_score(w_sc2[2*j*c_fb +: c_fb]),
                .i_b_label(w_lab2[(2*j+1)*c_lw +: c_lw]), .i_b_score(w_sc2[(2*j+1)*c_fb +: c_fb]),
                .o_label(w_lab3[j*c_lw +: c_lw]),         .o_score(w_sc3[j*c_fb +: c_fb]));
        end else begin : g_pass
            logic [c_lw-1:0] r_lab;
            logic [c_fb-1:0] r_sc;
            always_ff @(posedge clock) begin
                if (rst) begin r_lab <= '0; r_sc <= '0; end
                else begin r_lab <= w_lab2[2*j*c_lw +: c_lw]; r_sc <= w_sc2[2*j*c_fb +: c_fb]; end
            end
            assign w_lab3[j*c_lw +: c_lw] = r_lab;
            assign w_sc3[j*c_fb +: c_fb]  = r_sc;
        end
    end

    for (genvar j = 0; j < c_n4; j++) begin : g_s4
        if (2*j+1 < c_n3) begin : g_cmp
            seg_cmp2 #(.LABEL_BITW(c_lw), .FIXED_BITW(c_fb)) u_cmp2 (
                .clk(clock), .rst(rst),
                .i_a_label(w_lab3[2*j*c_lw +: c_lw]),     .i_a_score(w_sc3[2*j*c_fb +: c_fb]),
                .i_b_label(w_lab3[(2*j+1)*c_lw +: c_lw]), .i_b_score(w_sc3[(2*j+1)*c_fb +: c_fb]),
                .o_label(w_lab4[j*c_lw +: c_lw]),         .o_score(w_sc4[j*c_fb +: c_fb]));
        end else begin : g_pass
            logic [c_lw-1:0] r_lab;
            logic [c_fb-1:0] r_sc;
            always_ff @(posedge clock) begin
                if (rst) begin r_lab <= '0; r_sc <= '0; end
                else begin r_lab <= w_lab3[2*j*c_lw +: c_lw]; r_sc <= w_sc3[2*j*c_fb +: c_fb]; end
            end
            assign w_lab4[j*c_lw +: c_lw] = r_lab;
            assign w_sc4[j*c_fb +: c_fb]  = r_sc;
        end
    end

    assign out_label = w_lab4;
    assign out_score = w_sc4;

    logic [SEG_LATENCY-1:0][c_vcnt_bitw-1:0] r_vcnt_sr;
    logic [SEG_LATENCY-1:0][c_hcnt_bitw-1:0] r_hcnt_sr;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_vcnt_sr <= '0;
            r_hcnt_sr <= '0;
        end else begin
            r_vcnt_sr <= {r_vcnt_sr[SEG_LATENCY-2:0], in_vcnt};
            r_hcnt_sr <= {r_hcnt_sr[SEG_LATENCY-2:0], in_hcnt};
        end
    end

    assign out_vcnt = r_vcnt_sr[SEG_LATENCY-1];
    assign out_hcnt = r_hcnt_sr[SEG_LATENCY-1];

`ifdef SEG_HIST_EN
    localparam logic [c_vcnt_bitw-1:0] c_last_v = c_vcnt_bitw'(HEIGHT - 1);
    localparam logic [c_hcnt_bitw-1:0] c_last_h = c_hcnt_bitw'(WIDTH - 1);

    // r_live_sr marks stages holding pixels sampled after reset; r_armed is set
    // once a frame start is seen so a frame cut by reset is never emitted.
    logic [SEG_LATENCY-1:0]        r_live_sr;
    logic                          r_armed;
    logic                          r_hist_valid;
    logic [UNITS*c_cnt_bitw-1:0]   r_cnt;
    logic [UNITS*c_cnt_bitw-1:0]   r_hist_data;
    logic [UNITS*c_cnt_bitw-1:0]   w_snap;
    logic                          w_active;
    logic                          w_start;
    logic                          w_last;
    logic                          w_count;

    assign w_active = r_live_sr[SEG_LATENCY-1] && (out_vcnt <= c_last_v) && (out_hcnt <= c_last_h);
    assign w_start  = r_live_sr[SEG_LATENCY-1] && (out_vcnt == '0) && (out_hcnt == '0);
    assign w_last   = w_active && (out_vcnt == c_last_v) && (out_hcnt == c_last_h);
    assign w_count  = w_active && (r_armed || w_start);

    for (genvar k = 0; k < UNITS; k++) begin : g_snap
        assign w_snap[k*c_cnt_bitw +: c_cnt_bitw] = r_cnt[k*c_cnt_bitw +: c_cnt_bitw]
            + c_cnt_bitw'(w_count && (out_label == c_label_bitw'(k)));
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            r_live_sr    <= '0;
            r_armed      <= 1'b0;
            r_hist_valid <= 1'b0;
            r_cnt        <= '0;
            r_hist_data  <= '0;
        end else begin
            r_live_sr    <= {r_live_sr[SEG_LATENCY-2:0], 1'b1};
            r_hist_valid <= w_last && (r_armed || w_start);
            if (w_start) r_armed <= 1'b1;
            if (w_last) begin
                r_cnt <= '0;
                if (r_armed || w_start) r_hist_data <= w_snap;
            end else begin
                r_cnt <= w_snap;
            end
        end
    end

    assign hist_valid = r_hist_valid;
    assign hist_data  = r_hist_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_argmax.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_argmax
// Brief    : Scoreboard bench for seg_argmax on a 2x4 image in a 3x6 window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_argmax;

    logic         clock = 1'b0;
    logic         rst   = 1'b1;
    logic [155:0] in_y  = '0;
    logic [1:0]   in_vcnt = '0;
    logic [2:0]   in_hcnt = '0;
    logic [3:0]   out_label;
    logic [12:0]  out_score;
    logic [1:0]   out_vcnt;
    logic [2:0]   out_hcnt;
`ifdef SEG_HIST_EN
    logic         hist_valid;
    logic [47:0]  hist_data;
`endif

    seg_argmax #(
        .HEIGHT(2), .WIDTH(4), .W_HEIGHT(3), .W_WIDTH(6), .UNITS(12), .FIXED_BITW(13)
    ) dut (
        .clock     (clock),
        .rst       (rst),
        .in_y      (in_y),
        .in_vcnt   (in_vcnt),
        .in_hcnt   (in_hcnt),
        .out_label (out_label),
        .out_score (out_score),
        .out_vcnt  (out_vcnt),
`ifdef SEG_HIST_EN
        .hist_valid(hist_valid),
        .hist_data (hist_data),
`endif
        .out_hcnt  (out_hcnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          due;
        bit          zero;
        logic [3:0]  label;
        logic [12:0] score;
        logic [1:0]  v;
        logic [2:0]  h;
    } exp_t;

    exp_t q[$];
    int   cyc     = 0;
    int   n_pass  = 0;
    int   n_total = 0;
    bit   mon_en  = 1'b0;

`ifdef SEG_HIST_EN
    typedef struct {
        int          due;
        logic [47:0] counts;
    } hexp_t;
    hexp_t hq[$];
`endif

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [155:0] vec(input logic [12:0] base, input int ch_a,
                                         input logic [12:0] val_a, input int ch_b,
                                         input logic [12:0] val_b);
        logic [155:0] r;
        for (int k = 0; k < 12; k++) r[k*13 +: 13] = base;
        if (ch_a >= 0) r[ch_a*13 +: 13] = val_a;
        if (ch_b >= 0) r[ch_b*13 +: 13] = val_b;
        return r;
    endfunction

    // One pixel per clock; a reset cycle discards everything still in flight
    task automatic drive(input logic [155:0] y, input logic [1:0] v, input logic [2:0] h,
                         input logic [3:0] lab, input logic [12:0] sc, input bit do_rst);
        exp_t e;
        @(posedge clock);
        #1;
        in_y    = y;
        in_vcnt = v;
        in_hcnt = h;
        if (do_rst) begin
            rst = 1'b1;
            q.delete();
`ifdef SEG_HIST_EN
            hq.delete();
`endif
            e = '{due: cyc + 1, zero: 1'b1, label: '0, score: '0, v: '0, h: '0};
        end else begin
            rst = 1'b0;
            e = '{due: cyc + 4, zero: 1'b0, label: lab, score: sc, v: v, h: h};
        end
        q.push_back(e);
    endtask

    task automatic frame(input int pat, input bit rst_mid, input bit strobe,
                         input logic [47:0] counts);
        bit          act;
        int          lab;
        logic [12:0] sc;
        for (int v = 0; v < 3; v++) begin
            for (int h = 0; h < 6; h++) begin
                act = (v < 2) && (h < 4);
                if (!act)          lab = 5;
                else if (pat == 0) lab = h % 2;
                else               lab = (h + v) % 3;
                sc = act ? 13'(16 * v + h + 1) : 13'h0FFF;
                drive(vec(13'h1F00, lab, sc, -1, '0), 2'(v), 3'(h), 4'(lab), sc,
                      rst_mid && (v == 1) && (h == 1));
`ifdef SEG_HIST_EN
                if (strobe && (v == 1) && (h == 3))
                    hq.push_back('{due: cyc + 5, counts: counts});
`else
                if (strobe && (v == 1) && (h == 3) && (counts == '1)) lab = 0;
`endif
            end
        end
    endtask

    exp_t e_mon;
    bit   ok;

    always @(negedge clock) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                e_mon = q.pop_front();
                ok = (out_label == e_mon.label) && (out_score == e_mon.score) &&
                     (out_vcnt == e_mon.v) && (out_hcnt == e_mon.h);
`ifdef SEG_HIST_EN
                if (e_mon.zero) ok = ok && (hist_valid == 1'b0) && (hist_data == '0);
`endif
                n_total++;
                if (ok) n_pass++;
                else $display("FAIL %s cyc=%0d: got label=%0d score=%h v=%0d h=%0d, want label=%0d score=%h v=%0d h=%0d",
                              e_mon.zero ? "reset_zero" : "pixel", cyc, out_label, out_score,
                              out_vcnt, out_hcnt, e_mon.label, e_mon.score, e_mon.v, e_mon.h);
            end
`ifdef SEG_HIST_EN
            if (hist_valid) begin
                n_total++;
                if (hq.size() > 0 && hq[0].due == cyc) begin
                    if (hist_data == hq[0].counts) n_pass++;
                    else $display("FAIL hist_data cyc=%0d: got %h, want %h", cyc, hist_data, hq[0].counts);
                    void'(hq.pop_front());
                end else begin
                    $display("FAIL hist_strobe cyc=%0d: got unexpected hist_valid=1, want 0", cyc);
                end
            end else if (hq.size() > 0 && hq[0].due <= cyc) begin
                n_total++;
                $display("FAIL hist_strobe cyc=%0d: got hist_valid=0, want 1", cyc);
                void'(hq.pop_front());
            end
`endif
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int pend;
        repeat (3) @(posedge clock);
        drive('0, '0, '0, '0, '0, 1'b1);
        mon_en = 1'b1;

        // Directed vectors in the blanking row, so they never touch a histogram
        drive(vec(13'h1F00,  7, 13'h0100, -1, '0),       2'd2, 3'd0, 4'd7,  13'h0100, 1'b0);
        drive(vec(13'h1FFF, -1, '0, -1, '0),             2'd2, 3'd1, 4'd0,  13'h1FFF, 1'b0);
        drive(vec(13'h0000,  3, 13'h0FFF, 9, 13'h0FFF),  2'd2, 3'd2, 4'd3,  13'h0FFF, 1'b0);
        drive(vec(13'h1000,  1, 13'h0000, -1, '0),       2'd2, 3'd3, 4'd1,  13'h0000, 1'b0);
        drive(vec(13'h0010, 10, 13'h0050, 11, 13'h0050), 2'd2, 3'd4, 4'd10, 13'h0050, 1'b0);
        drive(vec(13'h0000, 11, 13'h0001, -1, '0),       2'd2, 3'd5, 4'd11, 13'h0001, 1'b0);
        drive(vec(13'h1800,  2, 13'h0ABC, 11, 13'h0ABC), 2'd2, 3'd0, 4'd2,  13'h0ABC, 1'b0);
        drive(vec(13'h0000, -1, '0, -1, '0),             2'd2, 3'd1, 4'd0,  13'h0000, 1'b0);
        drive(vec(13'h1000,  6, 13'h1001, -1, '0),       2'd2, 3'd2, 4'd6,  13'h1001, 1'b0);
        drive(vec(13'h0FFE,  4, 13'h0FFF, 5, 13'h1000),  2'd2, 3'd3, 4'd4,  13'h0FFF, 1'b0);

        // pattern 0 -> classes {4,4}; pattern 1 -> classes {3,3,2}
        frame(0, 1'b0, 1'b1, 48'h0000_0000_0044);
        frame(1, 1'b0, 1'b1, 48'h0000_0000_0233);
        frame(0, 1'b1, 1'b0, 48'h0000_0000_0000);
        frame(0, 1'b0, 1'b1, 48'h0000_0000_0044);

        repeat (8) @(posedge clock);
        #1;
        pend = q.size();
`ifdef SEG_HIST_EN
        pend = pend + hq.size();
`endif
        n_total++;
        if (pend == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expectations, want 0", pend);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
